// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: fetch/decode/execute/memory/write-back
// sequencing with a retired-instruction counter.
module mc_ctrl #(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_en,
   output logic [1:0]          pc_source,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic                ext_op,
   output logic                illegal,
   output logic [3:0]          state,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EX     = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_I_EX     = 4'd10,
      S_I_WB     = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] FN_JR   = 6'b001000;

   state_t cur;
   state_t nxt;
   logic   done;
   logic   sx;

   assign state = cur;

   always_comb begin
      sx = 1'b0;
      unique case (opcode)
         OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI: sx = 1'b1;
         default: sx = 1'b0;
      endcase
   end

   always_comb begin
      pc_en      = 1'b0;
      pc_source  = 2'b00;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      ext_op     = sx;
      illegal    = 1'b0;
      nxt        = cur;
      done       = 1'b0;
      unique case (cur)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ext_op    = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_en    = 1'b1;
               nxt      = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            unique case (opcode)
               OP_R: begin
                  if (funct == FN_JR) begin
                     illegal = 1'b1;
                     nxt     = S_FETCH;
                  end else begin
                     nxt = S_R_EX;
                  end
               end
               OP_LW, OP_SW:             nxt = S_MEM_ADDR;
               OP_BEQ, OP_BNE:           nxt = S_BRANCH;
               OP_J:                     nxt = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI: nxt = S_I_EX;
               default: begin
                  illegal = 1'b1;
                  nxt     = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) nxt = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            nxt        = S_FETCH;
            done       = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               nxt  = S_FETCH;
               done = 1'b1;
            end
         end
         S_R_EX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            nxt       = S_R_WB;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            nxt       = S_FETCH;
            done      = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_source = 2'b01;
            pc_en     = (opcode == OP_BNE) ? ~zero : zero;
            nxt       = S_FETCH;
            done      = 1'b1;
         end
         S_JUMP: begin
            pc_source = 2'b10;
            pc_en     = 1'b1;
            nxt       = S_FETCH;
            done      = 1'b1;
         end
         S_I_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
            nxt       = S_I_WB;
         end
         S_I_WB: begin
            reg_write = 1'b1;
            nxt       = S_FETCH;
            done      = 1'b1;
         end
         default: begin
            illegal = 1'b1;
            nxt     = S_FETCH;
         end
      endcase
      // Reset forces FETCH with every strobe but the fetch read held low
      if (reset) begin
         pc_en      = 1'b0;
         pc_source  = 2'b00;
         i_or_d     = 1'b0;
         mem_read   = 1'b1;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         reg_write  = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         alu_op     = 2'b00;
         ext_op     = 1'b0;
         illegal    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur     <= S_FETCH;
         retired <= '0;
      end else begin
         cur <= nxt;
         if (done) retired <= retired + RETIRE_W'(1);
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: instruction table, directed corner sequences and
// randomized instruction streams against a path-based reference model.
module tb_mc_ctrl;

   localparam int RW = 4;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_JR   = 6'b001000;

   typedef struct packed {
      logic       pc_en;
      logic [1:0] pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       ext_op;
      logic       illegal;
   } ctl_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         cyc;
      int         ret;
      int         ill;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [5:0]    opcode;
   logic [5:0]    funct;
   logic          zero;
   logic          mem_ready;
   logic          pc_en;
   logic [1:0]    pc_source;
   logic          i_or_d;
   logic          mem_read;
   logic          mem_write;
   logic          ir_write;
   logic          reg_dst;
   logic          mem_to_reg;
   logic          reg_write;
   logic          alu_src_a;
   logic [1:0]    alu_src_b;
   logic [1:0]    alu_op;
   logic          ext_op;
   logic          illegal;
   logic [3:0]    state;
   logic [RW-1:0] retired;
   ctl_t          act;

   int checks = 0;
   int errors = 0;
   int es;
   int er;
   int q[$];
   bit lg;
   int ill_seen;

   always #5 clk = ~clk;

   mc_ctrl #(.RETIRE_W(RW)) dut (
      .clk       (clk),
      .reset     (reset),
      .opcode    (opcode),
      .funct     (funct),
      .zero      (zero),
      .mem_ready (mem_ready),
      .pc_en     (pc_en),
      .pc_source (pc_source),
      .i_or_d    (i_or_d),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .ir_write  (ir_write),
      .reg_dst   (reg_dst),
      .mem_to_reg(mem_to_reg),
      .reg_write (reg_write),
      .alu_src_a (alu_src_a),
      .alu_src_b (alu_src_b),
      .alu_op    (alu_op),
      .ext_op    (ext_op),
      .illegal   (illegal),
      .state     (state),
      .retired   (retired)
   );

   assign act = {pc_en, pc_source, i_or_d, mem_read, mem_write,
                 ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                 alu_src_b, alu_op, ext_op, illegal};

   task automatic chk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, a, e);
      end
   endtask

   function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
      if (op == OP_R) return fn != FN_JR;
      return op inside {OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
                        OP_ADDI, OP_ANDI, OP_ORI};
   endfunction

   // Expected control word per state, straight from the state table
   function automatic ctl_t expc(input int s, input logic [5:0] op,
                                 input logic [5:0] fn, input logic z,
                                 input logic mr);
      ctl_t c = '0;
      case (s)
         0: begin
            c.mem_read = 1; c.alu_src_b = 2'b01;
            c.ir_write = mr; c.pc_en = mr;
         end
         1: begin
            c.alu_src_b = 2'b11; c.illegal = !legal(op, fn);
         end
         2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
         3: begin c.mem_read = 1; c.i_or_d = 1; end
         4: begin c.reg_write = 1; c.mem_to_reg = 1; end
         5: begin c.mem_write = 1; c.i_or_d = 1; end
         6: begin c.alu_src_a = 1; c.alu_op = 2'b10; end
         7: begin c.reg_write = 1; c.reg_dst = 1; end
         8: begin
            c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01;
            c.pc_en = (op == OP_BEQ) ? z : !z;
         end
         9: begin c.pc_source = 2'b10; c.pc_en = 1; end
         10: begin
            c.alu_src_a = 1; c.alu_src_b = 2'b10;
            c.alu_op = (op == OP_ADDI) ? 2'b00 : 2'b11;
         end
         11: c.reg_write = 1;
         default: c.illegal = 1;
      endcase
      c.ext_op = (s == 0) ? 1'b1 :
                 (op inside {OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI});
      return c;
   endfunction

   // Model: an instruction is a list of states, walked one per cycle
   task automatic advance(input logic mr);
      if ((es == 0 || es == 3 || es == 5) && !mr) return;
      if (es == 0) begin
         q.delete();
         lg = legal(opcode, funct);
         if (!lg) q = '{1};
         else case (opcode)
            OP_R:           q = '{1, 6, 7};
            OP_LW:          q = '{1, 2, 3, 4};
            OP_SW:          q = '{1, 2, 5};
            OP_BEQ, OP_BNE: q = '{1, 8};
            OP_J:           q = '{1, 9};
            default:        q = '{1, 10, 11};
         endcase
         es = q.pop_front();
      end else if (q.size() == 0) begin
         if (lg) er++;
         es = 0;
      end else begin
         es = q.pop_front();
      end
   endtask

   task automatic model_reset();
      es = 0;
      er = 0;
      q.delete();
      lg = 0;
   endtask

   task automatic tick(input logic mr, input logic z);
      mem_ready = mr;
      zero = z;
      @(negedge clk);
      if (illegal) ill_seen++;
      chk("state", 64'(state), 64'(es));
      chk("ctl", 64'(act), 64'(expc(es, opcode, funct, z, mr)));
      chk("retired", 64'(retired), 64'(er % (1 << RW)));
      @(posedge clk);
      advance(mr);
      #1;
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input bit rnd,
                            output int cyc, output int ill);
      bit go = 0;
      opcode = op;
      funct = fn;
      cyc = 0;
      ill_seen = 0;
      do begin
         tick(rnd ? logic'($urandom_range(0, 3) != 0) : 1'b1, z);
         cyc++;
         if (state != 4'd0) go = 1;
      end while ((!go || state != 4'd0) && cyc < 40);
      if (cyc >= 40) chk("timeout", 64'(cyc), 64'(0));
      ill = ill_seen;
   endtask

   vec_t vt[11];
   logic [5:0] ops[11];

   initial begin
      int cyc;
      int ill;
      logic [RW-1:0] r0;

      vt[0]  = '{OP_R,    FN_ADD, 1'b0, 4, 1, 0};
      vt[1]  = '{OP_R,    FN_JR,  1'b0, 2, 0, 1};
      vt[2]  = '{OP_LW,   6'h00,  1'b0, 5, 1, 0};
      vt[3]  = '{OP_SW,   6'h00,  1'b0, 4, 1, 0};
      vt[4]  = '{OP_BEQ,  6'h00,  1'b1, 3, 1, 0};
      vt[5]  = '{OP_BNE,  6'h00,  1'b1, 3, 1, 0};
      vt[6]  = '{OP_J,    6'h00,  1'b0, 3, 1, 0};
      vt[7]  = '{OP_ORI,  6'h00,  1'b0, 4, 1, 0};
      vt[8]  = '{OP_ADDI, 6'h00,  1'b0, 4, 1, 0};
      vt[9]  = '{OP_ANDI, 6'h00,  1'b0, 4, 1, 0};
      vt[10] = '{6'b111111, 6'h00, 1'b0, 2, 0, 1};

      ops = '{OP_R, OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
              OP_ADDI, OP_ANDI, OP_ORI, 6'b010001};

      reset = 1'b1;
      opcode = OP_LW;
      funct = 6'h00;
      zero = 1'b0;
      mem_ready = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_state", 64'(state), 64'(0));
      chk("rst_retired", 64'(retired), 64'(0));
      chk("rst_mem_read", 64'(mem_read), 64'(1));
      chk("rst_ir_write", 64'(ir_write), 64'(0));
      chk("rst_pc_en", 64'(pc_en), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         r0 = retired;
         run_instr(vt[i].op, vt[i].fn, vt[i].z, 1'b0, cyc, ill);
         chk($sformatf("lat_%0d", i), 64'(cyc), 64'(vt[i].cyc));
         chk($sformatf("ret_%0d", i), 64'(RW'(retired - r0)),
             64'(vt[i].ret));
         chk($sformatf("ill_%0d", i), 64'(ill), 64'(vt[i].ill));
      end

      // Reset while a store waits on memory
      opcode = OP_SW;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      mem_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_rst_state", 64'(state), 64'(0));
      chk("mid_rst_mem_write", 64'(mem_write), 64'(0));
      chk("mid_rst_retired", 64'(retired), 64'(0));
      mem_ready = 1'b1;
      #1;
      chk("mid_rst_ir_write", 64'(ir_write), 64'(0));
      chk("mid_rst_pc_en", 64'(pc_en), 64'(0));
      @(posedge clk);
      #1;
      model_reset();
      reset = 1'b0;
      opcode = OP_J;
      tick(1'b0, 1'b0);

      // Counter wrap from all-ones
      for (int i = 0; i < 15; i++)
         run_instr(OP_J, 6'h00, 1'b0, 1'b0, cyc, ill);
      chk("wrap_full", 64'(retired), 64'(15));
      run_instr(OP_R, FN_ADD, 1'b0, 1'b0, cyc, ill);
      chk("wrap_zero", 64'(retired), 64'(0));

      // Fetch stalled for three cycles
      opcode = OP_J;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      mem_ready = 1'b1;
      #1;
      chk("stall_ir_write", 64'(ir_write), 64'(1));
      chk("stall_pc_en", 64'(pc_en), 64'(1));
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);

      for (int i = 0; i < 80; i++) begin
         int k = int'($urandom_range(0, 10));
         logic [5:0] fn = (k == 1) ? FN_JR : 6'($urandom);
         run_instr(ops[k], fn, logic'($urandom_range(0, 1)), 1'b1,
                   cyc, ill);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Drives the immediate extender mode (ext_op), ALU operand selects, memory strobes and register-file and PC enables.
- Sits between the instruction register opcode/funct fields and the shared ALU/memory datapath.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26].
- funct  input  6  IR[5:0]; used only to flag jr as illegal.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access completes this cycle.
- pc_en  output  1  PC register load enable.
- pc_source  output  2  PC mux select: 00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  output  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  IR load enable.
- reg_dst  output  1  write register select: 0 rt, 1 rd.
- mem_to_reg  output  1  write-back data select: 0 ALUOut, 1 MDR.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  ALU A select: 0 PC, 1 register A.
- alu_src_b  output  2  ALU B select: 00 B, 01 const 4, 10 ext imm, 11 ext imm<<2.
- alu_op  output  2  00 add, 01 sub, 10 funct-decode, 11 logic-imm.
- ext_op  output  1  immediate extender mode: 1 sign-extend, 0 zero-extend.
- illegal  output  1  one-cycle pulse on an unsupported opcode.
- state  output  4  current state, for debug.
- retired  output  RETIRE_W  count of completed instructions.

Behaviour:
- State register and retired counter update on rising clk.
- reset clears state to FETCH (0) and retired to 0 asynchronously.
- While reset is asserted, all control outputs are 0 except mem_read=1 (FETCH values, gated to 0 by reset).
- Reset mid-instruction abandons it: no reg_write, no mem_write, no pc_en after reset releases until a new FETCH completes.
- Outputs are a Moore decode of state plus combinational use of mem_ready, zero and opcode where noted; every unlisted output is 0 in a state.
- States and encodings:
  - FETCH=0: mem_read=1, alu_src_b=01, alu_op=00. If mem_ready: ir_write=1, pc_en=1, pc_source=00, next DECODE; else hold in FETCH.
  - DECODE=1: alu_src_b=11, alu_op=00 (branch target into ALUOut). Dispatch on opcode:
    - 000000 (R) -> R_EX; if funct==001000 (jr, unsupported) -> FETCH with illegal=1.
    - 100011 lw / 101011 sw -> MEM_ADDR.
    - 000100 beq / 000101 bne -> BRANCH.
    - 000010 j -> JUMP.
    - 001000 addi / 001100 andi / 001101 ori -> I_EX.
    - Any other opcode -> FETCH, illegal=1, retired unchanged.
  - MEM_ADDR=2: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEM_RD for lw, MEM_WR for sw.
  - MEM_RD=3: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
  - MEM_WB=4: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH, retired+1.
  - MEM_WR=5: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH, retired+1.
  - R_EX=6: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
  - R_WB=7: reg_write=1, reg_dst=1. Next FETCH, retired+1.
  - BRANCH=8: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01. pc_en = zero for beq, ~zero for bne. Next FETCH, retired+1.
  - JUMP=9: pc_source=10, pc_en=1. Next FETCH, retired+1.
  - I_EX=10: alu_src_a=1, alu_src_b=10; alu_op=00 for addi, 11 for andi/ori. Next I_WB.
  - I_WB=11: reg_write=1, reg_dst=0. Next FETCH, retired+1.
  - Encodings 12-15 are unreachable; if entered, go to FETCH and pulse illegal.
- ext_op: 1 for lw, sw, beq, bne, addi; 0 for andi, ori. It is valid from DECODE through the instruction's last state, decoded from opcode. In FETCH ext_op=1.
- retired wraps from all-ones to 0 silently.
- Latency without memory waits: R/addi/andi/ori 4 cycles, lw 5, sw 4, beq/bne/j 3. Each mem_ready-low cycle adds 1.

Test Plan:
- Reset asserted mid-MEM_WR with mem_ready=0 -> state=0 immediately, mem_write=0, retired=0; after release, FETCH with mem_read=1.
- lw (opcode 100011), mem_ready always 1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; ext_op=1; retired=1.
- ori (001101) then addi (001000) -> ext_op=0 during ori states 1,10,11; ext_op=1 during addi; alu_op=11 then 00 in state 10; retired=2.
- beq with zero=1, then bne with zero=1 -> pc_en=1 in BRANCH for beq, pc_en=0 for bne; pc_source=01 in both.
- FETCH with mem_ready low for 3 cycles -> state stays 0, ir_write=0, pc_en=0; on the 4th cycle with mem_ready=1, ir_write=pc_en=1.
- opcode 111111, then R-type with funct 001000 -> illegal pulses 1 cycle in DECODE each time, next state 0, retired unchanged. Separately, preload retired to all-ones and complete an instruction -> retired=0.
